// File: rtl/led_pwm_breathe.sv
// -----------------------------------------------------------------------------
// led_pwm_breathe
//
// Purpose:
//   Produces the three PWM drive signals for the iCE40 SB_RGBA_DRV LED macro.
//   Each channel either runs at a fixed duty (written through a double-buffered
//   shadow register) or follows a shared triangular "breathing" level that
//   ramps 0 -> MAX -> 0 one step every STEP_DIV PWM periods.
//
//   A PWM period is MAX = 2**PWM_BITS-1 counts of PRESCALE clk cycles each.
//   Duty values and the breathing level only change on the last clk of a
//   period (the boundary), so every period compares against one stable value.
//
// Parameters:
//   PWM_BITS  width of PWM counter, duty values and breathing level
//   PRESCALE  clk cycles per PWM count (>= 1)
//   STEP_DIV  PWM periods per breathing level step (>= 1)
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   en[2:0]      per-channel enable (bit i drives RGBiPWM)
//   breathe[2:0] per-channel source: 1 = breathing level, 0 = fixed duty
//   duty_wr      single-cycle duty write strobe
//   duty_sel     channel index for the write (3 is ignored)
//   duty_data    duty value to write
//   pwm_out      registered PWM outputs
//   level        current breathing level
//   period_tick  one-cycle pulse on the last clk of each PWM period
//
// Handshake: there is no valid/ready flow here. duty_wr is a plain strobe:
//   every cycle it is high with duty_sel in 0..2, shadow[duty_sel] takes
//   duty_data. There is no back-pressure and the last write before a boundary
//   is the one that reaches the active register.
// -----------------------------------------------------------------------------
module led_pwm_breathe #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 94,
  parameter int STEP_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          en,
  input  logic [2:0]          breathe,
  input  logic                duty_wr,
  input  logic [1:0]          duty_sel,
  input  logic [PWM_BITS-1:0] duty_data,
  output logic [2:0]          pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                period_tick
);

  // Counter widths never collapse to zero bits, even for PRESCALE/STEP_DIV = 1.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MAX_M1  = MAX - 1'b1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SC_W-1:0]     SC_LAST = SC_W'(STEP_DIV - 1);

  typedef enum logic {
    ST_RISE = 1'b0,
    ST_FALL = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0]     prescale_q, prescale_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
  logic [SC_W-1:0]     step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] level_q,    level_d;
  state_e              state_q,    state_d;
  logic [PWM_BITS-1:0] shadow_q [3];
  logic [PWM_BITS-1:0] shadow_d [3];
  logic [PWM_BITS-1:0] active_q [3];
  logic [PWM_BITS-1:0] active_d [3];
  logic [2:0]          pwm_out_q,  pwm_out_d;

  // Combinational helpers
  logic                tick;
  logic                boundary;
  logic [PWM_BITS-1:0] sel [3];

  // ---------------------------------------------------------------------------
  // Timebase: prescaler and PWM counter
  // ---------------------------------------------------------------------------
  always_comb begin
    tick     = (prescale_q == PS_LAST);
    boundary = tick && (pwm_cnt_q == MAX_M1);

    prescale_d = tick ? '0 : prescale_q + 1'b1;

    // The counter spans 0..MAX-1 so that duty MAX is high for the whole
    // period and duty 0 is low for the whole period.
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == MAX_M1) ? '0 : pwm_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty buffering, compare mux and output compare
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shadow_d[i] = shadow_q[i];
      if (duty_wr && (duty_sel == 2'(i))) begin
        shadow_d[i] = duty_data;
      end
      // Loading from shadow_d (not shadow_q) forwards a write that lands in
      // the boundary cycle straight into the active register.
      active_d[i] = boundary ? shadow_d[i] : active_q[i];

      // The breathe select is deliberately unbuffered: toggling it takes
      // effect on the next clk rather than at the next boundary.
      sel[i]       = breathe[i] ? level_q : active_q[i];
      pwm_out_d[i] = en[i] && (sel[i] > pwm_cnt_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Breathing ramp: step_cnt divides boundaries down to level steps, the
  // RISE/FALL state picks the step direction and turns around at the ends.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_cnt_d = step_cnt_q;
    level_d    = level_q;
    state_d    = state_q;
    if (boundary) begin
      if (step_cnt_q == SC_LAST) begin
        step_cnt_d = '0;
        case (state_q)
          ST_RISE: begin
            level_d = level_q + 1'b1;
            if (level_d == MAX) begin
              state_d = ST_FALL;
            end
          end
          ST_FALL: begin
            level_d = level_q - 1'b1;
            if (level_d == '0) begin
              state_d = ST_RISE;
            end
          end
        endcase
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      level_q    <= '0;
      state_q    <= ST_RISE;
      pwm_out_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      prescale_q <= prescale_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      pwm_out_q  <= pwm_out_d;
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out     = pwm_out_q;
  assign level       = level_q;
  assign period_tick = boundary;

endmodule

// File: tb/tb_led_pwm_breathe.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_breathe
//
// Directed bench for led_pwm_breathe with PWM_BITS=3, PRESCALE=2, STEP_DIV=1
// (MAX=7, period=14 clk). Inputs are driven 1 ns after the falling edge and
// outputs are sampled there too. A negedge monitor counts high samples per
// channel over each PWM window (the 14 samples that reflect one period's
// counter values, i.e. shifted one clk by the output register) and records
// the level that was in force during that period.
// -----------------------------------------------------------------------------
module tb_led_pwm_breathe;

  localparam int PWM_BITS = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          en = 3'b000;
  logic [2:0]          breathe = 3'b000;
  logic                duty_wr = 1'b0;
  logic [1:0]          duty_sel = 2'd0;
  logic [PWM_BITS-1:0] duty_data = '0;
  logic [2:0]          pwm_out;
  logic [PWM_BITS-1:0] level;
  logic                period_tick;

  always #5 clk = ~clk;

  led_pwm_breathe #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (2),
    .STEP_DIV (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .breathe     (breathe),
    .duty_wr     (duty_wr),
    .duty_sel    (duty_sel),
    .duty_data   (duty_data),
    .pwm_out     (pwm_out),
    .level       (level),
    .period_tick (period_tick)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Per-period monitor
  // ---------------------------------------------------------------------------
  int   acc [3];
  int   last_hi [3];
  int   lvl_cur = 0;
  int   last_lvl = 0;
  int   period_count = 0;
  logic prev_pt = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) acc[i] = 0;
      prev_pt = 1'b0;
      lvl_cur = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pwm_out[i]) acc[i] = acc[i] + 1;
      end
      if (prev_pt) begin
        for (int i = 0; i < 3; i++) begin
          last_hi[i] = acc[i];
          acc[i] = 0;
        end
        last_lvl = lvl_cur;
        period_count = period_count + 1;
      end
      if (period_tick) lvl_cur = int'(level);
      prev_pt = period_tick;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Holds the write strobe for exactly one rising edge.
  task automatic write_duty(input logic [1:0] sel, input logic [PWM_BITS-1:0] data);
    duty_wr   = 1'b1;
    duty_sel  = sel;
    duty_data = data;
    tick_n(1);
    duty_wr   = 1'b0;
  endtask

  // Waits for the monitor to close the next window; an expired bound counts
  // as a failed comparison.
  task automatic wait_period(output int h0, output int h1, output int h2, output int lv);
    int start;
    int n;
    start = period_count;
    n = 0;
    while (period_count == start && n < 40) begin
      tick_n(1);
      n++;
    end
    if (period_count == start) begin
      checks++;
      failures++;
      $display("FAIL wait_period: no period end within %0d clk", n);
    end
    h0 = last_hi[0];
    h1 = last_hi[1];
    h2 = last_hi[2];
    lv = last_lvl;
  endtask

  task automatic apply_reset(input logic [2:0] en_v, input logic [2:0] br_v);
    rst = 1'b1;
    tick_n(2);
    en      = en_v;
    breathe = br_v;
    rst     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic exp_pt;
    logic [PWM_BITS-1:0] exp_lv;
    rst = 1'b1;
    tick_n(5);
    checks++;
    if (pwm_out !== 3'b000 || level !== 3'd0 || period_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: pwm_out=%b level=%0d period_tick=%b, need 000/0/0",
               pwm_out, level, period_tick);
    end
    en  = 3'b111;
    rst = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      if (k > 1) tick_n(1);
      exp_pt = (k == 14 || k == 28);
      exp_lv = (k <= 14) ? 3'd0 : 3'd1;
      checks++;
      if (period_tick !== exp_pt) begin
        failures++;
        $display("FAIL reset_period_tick: cycle %0d got %b need %b", k, period_tick, exp_pt);
      end
      checks++;
      if (pwm_out !== 3'b000 || level !== exp_lv) begin
        failures++;
        $display("FAIL reset_outputs: cycle %0d pwm_out=%b level=%0d need 000/%0d",
                 k, pwm_out, level, exp_lv);
      end
    end
  endtask

  task automatic test_fixed_duty();
    int h0, h1, h2, lv;
    en = 3'b001;
    breathe = 3'b000;
    write_duty(2'd0, 3'd3);
    wait_period(h0, h1, h2, lv);
    for (int p = 0; p < 2; p++) begin
      wait_period(h0, h1, h2, lv);
      checks++;
      if (h0 !== 6 || h1 !== 0 || h2 !== 0) begin
        failures++;
        $display("FAIL fixed_duty_count: highs ch0/1/2=%0d/%0d/%0d need 6/0/0", h0, h1, h2);
      end
    end
    // Window position: high on window samples 1..6, low from sample 7.
    tick_n(1);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_duty_first: got %b need 1", pwm_out[0]);
    end
    tick_n(5);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_duty_sixth: got %b need 1", pwm_out[0]);
    end
    tick_n(1);
    checks++;
    if (pwm_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL fixed_duty_seventh: got %b need 0", pwm_out[0]);
    end
  endtask

  task automatic test_extremes();
    int h0, h1, h2, lv;
    en = 3'b010;
    write_duty(2'd1, 3'd7);
    wait_period(h0, h1, h2, lv);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h1 !== 14) begin
      failures++;
      $display("FAIL duty_max: ch1 highs=%0d need 14", h1);
    end
    write_duty(2'd1, 3'd0);
    wait_period(h0, h1, h2, lv);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h1 !== 0) begin
      failures++;
      $display("FAIL duty_zero: ch1 highs=%0d need 0", h1);
    end
    write_duty(2'd1, 3'd7);
    wait_period(h0, h1, h2, lv);
    wait_period(h0, h1, h2, lv);
    en = 3'b000;
    checks++;
    if (pwm_out[1] !== 1'b1) begin
      failures++;
      $display("FAIL en_off_before_edge: got %b need 1", pwm_out[1]);
    end
    tick_n(1);
    checks++;
    if (pwm_out[1] !== 1'b0) begin
      failures++;
      $display("FAIL en_off_after_edge: got %b need 0", pwm_out[1]);
    end
  endtask

  task automatic test_mid_period_write();
    int h0, h1, h2, lv;
    int n;
    en = 3'b100;
    write_duty(2'd2, 3'd2);
    wait_period(h0, h1, h2, lv);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 4) begin
      failures++;
      $display("FAIL duty2_initial: ch2 highs=%0d need 4", h2);
    end
    tick_n(6);  // pwm_cnt == 3
    write_duty(2'd2, 3'd5);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 4) begin
      failures++;
      $display("FAIL write_current_period: ch2 highs=%0d need 4", h2);
    end
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 10) begin
      failures++;
      $display("FAIL write_next_period: ch2 highs=%0d need 10", h2);
    end
    tick_n(2);
    write_duty(2'd2, 3'd1);
    tick_n(3);
    write_duty(2'd2, 3'd6);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 10) begin
      failures++;
      $display("FAIL two_writes_current: ch2 highs=%0d need 10", h2);
    end
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 12) begin
      failures++;
      $display("FAIL last_write_wins: ch2 highs=%0d need 12", h2);
    end
    write_duty(2'd3, 3'd7);
    wait_period(h0, h1, h2, lv);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 12) begin
      failures++;
      $display("FAIL sel3_ignored: ch2 highs=%0d need 12", h2);
    end
    // Write landing in the boundary cycle itself.
    n = 0;
    while (period_tick !== 1'b1 && n < 30) begin
      tick_n(1);
      n++;
    end
    checks++;
    if (period_tick !== 1'b1) begin
      failures++;
      $display("FAIL boundary_search: period_tick=%b need 1", period_tick);
    end
    write_duty(2'd2, 3'd3);
    wait_period(h0, h1, h2, lv);
    checks++;
    if (h2 !== 6) begin
      failures++;
      $display("FAIL boundary_forward: ch2 highs=%0d need 6", h2);
    end
  endtask

  task automatic test_breathing();
    int h0, h1, h2, lv;
    int exp_lv [16];
    exp_lv = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    apply_reset(3'b001, 3'b001);
    for (int p = 0; p < 16; p++) begin
      wait_period(h0, h1, h2, lv);
      checks++;
      if (lv !== exp_lv[p]) begin
        failures++;
        $display("FAIL breathe_level: period %0d level=%0d need %0d", p, lv, exp_lv[p]);
      end
      checks++;
      if (h0 !== 2 * exp_lv[p]) begin
        failures++;
        $display("FAIL breathe_duty: period %0d ch0 highs=%0d need %0d", p, h0, 2 * exp_lv[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    int h0, h1, h2, lv;
    apply_reset(3'b001, 3'b001);
    repeat (9) wait_period(h0, h1, h2, lv);
    checks++;
    if (level !== 3'd5) begin
      failures++;
      $display("FAIL pre_reset_level: got %0d need 5", level);
    end
    tick_n(3);
    #2;
    checks++;
    if (pwm_out !== 3'b001) begin
      failures++;
      $display("FAIL pre_reset_pwm: got %b need 001", pwm_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pwm_out !== 3'b000 || level !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: pwm_out=%b level=%0d need 000/0", pwm_out, level);
    end
    tick_n(2);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_period(h0, h1, h2, lv);
      checks++;
      if (lv !== p) begin
        failures++;
        $display("FAIL post_reset_rise: period %0d level=%0d need %0d", p, lv, p);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fixed_duty();
    test_extremes();
    test_mid_period_write();
    test_breathing();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
